conv1_fmap_reader: RTL

Downstream consumer of the conv1 engine output. On the rising edge of done_conv it snapshots the full 12x12x18 binary out_fmap. It then streams the snapshot one spatial position per beat, each beat carrying all 18 channel bits, over a valid/ready interface to the next layer or a memory writer. This frees the engine to start the next image while the previous feature map drains.

---
 rtl/conv1_fmap_reader_if.sv | 42 ++++
 rtl/conv1_fmap_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/conv1_fmap_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : conv1_fmap_reader_if
// Brief    : Valid/ready beat stream carrying one feature-map position
//            (all channel bits plus its row/column coordinates) per beat.
// Options  : CONV1_READER_POPCNT_EN adds the m_popcnt field.
// Revision : 1.0 - initial release
// ============================================================================
interface conv1_fmap_reader_if #(
    parameter int CH   = 18,
    parameter int IDXW = 4
);
    logic            m_valid;
    logic            m_ready;
    logic [CH-1:0]   m_data;
    logic [IDXW-1:0] m_row;
    logic [IDXW-1:0] m_col;
    logic            m_last;

`ifdef CONV1_READER_POPCNT_EN
    logic [$clog2(CH+1)-1:0] m_popcnt;

    modport master (
        output m_valid, m_data, m_row, m_col, m_last, m_popcnt,
        input  m_ready
    );
    modport slave (
        input  m_valid, m_data, m_row, m_col, m_last, m_popcnt,
        output m_ready
    );
`else
    modport master (
        output m_valid, m_data, m_row, m_col, m_last,
        input  m_ready
    );
    modport slave (
        input  m_valid, m_data, m_row, m_col, m_last,
        output m_ready
    );
`endif
endinterface
`default_nettype wire

// File: rtl/conv1_fmap_reader.sv
`default_nettype none
// ============================================================================
// Module   : conv1_fmap_reader
// Brief    : Snapshots the conv1 binary output feature map on the rising edge
//            of done_conv and drains it one spatial position per beat
//            (row-major, column fastest) over a valid/ready stream, so the
//            engine can start the next image while this one drains.
// Options  : CONV1_READER_POPCNT_EN adds m_popcnt (ones count of m_data).
// Revision : 1.0 - initial release
// ============================================================================
module conv1_fmap_reader #(
    parameter int ROWS = 12,
    parameter int COLS = 12,
    parameter int CH   = 18,
    parameter int IDXW = 4
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              done_conv,
    input  wire logic [0:ROWS-1][0:COLS-1][0:CH-1] out_fmap,
    conv1_fmap_reader_if.master                    strm,
    output logic                                   busy,
    output logic                                   overrun
);

    localparam logic [IDXW-1:0] c_LAST_ROW = IDXW'(ROWS - 1);
    localparam logic [IDXW-1:0] c_LAST_COL = IDXW'(COLS - 1);
`ifdef CONV1_READER_POPCNT_EN
    localparam int c_PCW = $clog2(CH + 1);
`endif

    typedef logic [0:ROWS-1][0:COLS-1][0:CH-1] fmap_t;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t          state_q;
    logic            done_prev_q;
    fmap_t           snap_q;
    logic            valid_q;
    logic [CH-1:0]   data_q;
    logic [IDXW-1:0] row_q;
    logic [IDXW-1:0] col_q;
    logic            last_q;
    logic            overrun_q;
`ifdef CONV1_READER_POPCNT_EN
    logic [c_PCW-1:0] pcnt_q;
    logic [c_PCW-1:0] pcnt_d;
`endif

    // Next beat contents
    logic [IDXW-1:0] row_d;
    logic [IDXW-1:0] col_d;
    logic [CH-1:0]   data_d;
    logic            last_d;
    logic [0:CH-1]   w_beat;

    // Event decode
    logic w_done_rise;
    logic w_xfer;
    logic w_frame_end;
    logic w_capture;
    logic w_drop;

    assign w_done_rise = done_conv & ~done_prev_q;
    assign w_xfer      = valid_q & strm.m_ready;
    assign w_frame_end = w_xfer & last_q;
    // A new frame is accepted when idle, or exactly on the final transfer of
    // the current frame so consecutive frames stream without a bubble.
    assign w_capture   = w_done_rise & ((state_q == S_IDLE) | w_frame_end);
    // Any other rise while a frame is still draining is lost.
    assign w_drop      = w_done_rise & (state_q == S_STREAM) & ~w_frame_end;

    // Coordinates of the beat to present after this edge.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (w_capture) begin
            row_d = '0;
            col_d = '0;
        end else if (col_q == c_LAST_COL) begin
            row_d = row_q + IDXW'(1);
            col_d = '0;
        end else begin
            col_d = col_q + IDXW'(1);
        end
    end

    // Fetch the next beat; on capture the snapshot is not yet written, so the
    // first beat comes straight from the engine output.
    always_comb begin
        w_beat = '0;
        data_d = '0;
        if (w_capture) begin
            w_beat = out_fmap[0][0];
        end else begin
            w_beat = snap_q[row_d][col_d];
        end
        // Channel k of the map lands on bit k of the stream word.
        for (int k = 0; k < CH; k++) begin
            data_d[k] = w_beat[k];
        end
        last_d = (row_d == c_LAST_ROW) && (col_d == c_LAST_COL);
    end

`ifdef CONV1_READER_POPCNT_EN
    // Ones count of the next beat, registered together with its data.
    always_comb begin
        pcnt_d = '0;
        for (int k = 0; k < CH; k++) begin
            pcnt_d = pcnt_d + c_PCW'(data_d[k]);
        end
    end
`endif

    // Snapshot storage, written only when a frame is accepted.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            snap_q <= out_fmap;
        end
    end

    // Control FSM with registered stream outputs (zeroed whenever invalid).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            done_prev_q <= 1'b0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            last_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef CONV1_READER_POPCNT_EN
            pcnt_q      <= '0;
`endif
        end else begin
            done_prev_q <= done_conv;
            if (w_drop) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_capture) begin
                        state_q <= S_STREAM;
                        valid_q <= 1'b1;
                        data_q  <= data_d;
                        row_q   <= row_d;
                        col_q   <= col_d;
                        last_q  <= last_d;
`ifdef CONV1_READER_POPCNT_EN
                        pcnt_q  <= pcnt_d;
`endif
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (!last_q || w_capture) begin
                            valid_q <= 1'b1;
                            data_q  <= data_d;
                            row_q   <= row_d;
                            col_q   <= col_d;
                            last_q  <= last_d;
`ifdef CONV1_READER_POPCNT_EN
                            pcnt_q  <= pcnt_d;
`endif
                        end else begin
                            state_q <= S_IDLE;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                            last_q  <= 1'b0;
`ifdef CONV1_READER_POPCNT_EN
                            pcnt_q  <= '0;
`endif
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign strm.m_valid  = valid_q;
    assign strm.m_data   = data_q;
    assign strm.m_row    = row_q;
    assign strm.m_col    = col_q;
    assign strm.m_last   = last_q;
`ifdef CONV1_READER_POPCNT_EN
    assign strm.m_popcnt = pcnt_q;
`endif
    // The snapshot is pending exactly while the FSM is streaming.
    assign busy    = (state_q == S_STREAM);
    assign overrun = overrun_q;

endmodule
`default_nettype wire
